// File: rtl/compare_sequencer_if.sv
// compare_sequencer_if: switch, comparator-flag and status bundle between the sequencer and its board/datapath
interface compare_sequencer_if;
  logic [9:0] SW;
  logic       CMP_GT;
  logic       CMP_LT;
  logic       CMP_EQ;
  logic [3:0] OPA;
  logic [3:0] OPB;
  logic [1:0] MODE;
  logic [9:0] LEDR;
  logic [1:0] STATE;
  logic [7:0] CNT;
  modport master(input SW, CMP_GT, CMP_LT, CMP_EQ, output OPA, OPB, MODE, LEDR, STATE, CNT);
  modport slave(output SW, CMP_GT, CMP_LT, CMP_EQ, input OPA, OPB, MODE, LEDR, STATE, CNT);
endinterface

// File: rtl/compare_sequencer.sv
// compare_sequencer: debounced step button walks operand A / operand B capture, one-clock settle,
// then latches comparator flags onto the LEDs and holds them for a timed display window.
module compare_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SHOW_CYCLES     = 150000000
) (
  input  logic MAX10_CLK1_50,
  input  logic RST_N,
  input  logic STEP_N,
  compare_sequencer_if.master bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT_B = 2'd1;
  localparam logic [1:0] EVAL   = 2'd2;
  localparam logic [1:0] SHOW   = 2'd3;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(SHOW_CYCLES + 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TMAX = TW'(SHOW_CYCLES - 1);
  logic          s1, s2, db, db_d, armed;
  logic [1:0]    v;
  logic [DW-1:0] dcnt;
  logic [TW-1:0] tmr;
  logic [1:0]    state;
  logic [3:0]    opa, opb;
  logic [1:0]    mode;
  logic [2:0]    res;
  logic          err;
  logic [7:0]    cnt;
  logic [2:0]    flags;
  logic          press, ok, timeout;
  logic          unused_sw;
  assign unused_sw = &{1'b0, bus.SW[7:4]};
  assign flags     = {bus.CMP_GT, bus.CMP_LT, bus.CMP_EQ};
  assign ok        = $onehot(flags);
  assign timeout   = tmr == TMAX;
  // armed stays low until a real high level is seen, so a press held through reset never fires
  assign press     = armed & db_d & ~db;
  always_ff @(posedge MAX10_CLK1_50 or negedge RST_N)
    if (!RST_N) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      v     <= 2'b00;
      db    <= 1'b1;
      db_d  <= 1'b1;
      dcnt  <= '0;
      armed <= 1'b0;
    end else begin
      s1    <= STEP_N;
      s2    <= s1;
      v     <= {v[0], 1'b1};
      db_d  <= db;
      armed <= armed | (v[1] & s2 & db);
      if (s2 == db) dcnt <= '0;
      else if (dcnt == DMAX) begin
        db   <= s2;
        dcnt <= '0;
      end else dcnt <= dcnt + 1'b1;
    end
  always_ff @(posedge MAX10_CLK1_50 or negedge RST_N)
    if (!RST_N) begin
      state <= IDLE;
      opa   <= '0;
      opb   <= '0;
      mode  <= '0;
      res   <= '0;
      err   <= 1'b0;
      cnt   <= '0;
      tmr   <= '0;
    end else
      case (state)
        IDLE: if (press) begin
          opa   <= bus.SW[3:0];
          mode  <= bus.SW[9:8];
          state <= WAIT_B;
        end
        WAIT_B: if (press) begin
          opb   <= bus.SW[3:0];
          state <= EVAL;
        end
        EVAL: begin
          res   <= flags;
          err   <= ~ok;
          cnt   <= cnt + {7'd0, ok};
          tmr   <= '0;
          state <= SHOW;
        end
        default: if (press || timeout) begin
          res   <= '0;
          err   <= 1'b0;
          state <= IDLE;
        end else tmr <= tmr + 1'b1;
      endcase
  assign bus.OPA   = opa;
  assign bus.OPB   = opb;
  assign bus.MODE  = mode;
  assign bus.STATE = state;
  assign bus.CNT   = cnt;
  assign bus.LEDR  = {mode, 4'b0001 << state, err, res};
endmodule

// File: tb/tb_compare_sequencer.sv
// tb_compare_sequencer: directed vector table plus hand-timed sequences for debounce, timeout and reset
module tb_compare_sequencer;
  typedef struct {
    logic [9:0] sw_a;
    logic [3:0] sw_b;
    logic [2:0] flags;
    logic [3:0] exp_opa;
    logic [1:0] exp_mode;
    logic [3:0] exp_led;
    logic       inc;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic step_n = 1'b1;
  int total = 0;
  int bad = 0;
  logic [7:0] cnt_m = 8'd0;
  vec_t vecs[6];
  compare_sequencer_if bus();
  compare_sequencer #(.DEBOUNCE_CYCLES(4), .SHOW_CYCLES(20)) dut (
    .MAX10_CLK1_50(clk),
    .RST_N(rst_n),
    .STEP_N(step_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press();
    step_n = 1'b0;
    ticks(8);
    step_n = 1'b1;
    ticks(8);
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_state"}, bus.STATE, 0);
    chk({tag, "_opa"}, bus.OPA, 0);
    chk({tag, "_opb"}, bus.OPB, 0);
    chk({tag, "_mode"}, bus.MODE, 0);
    chk({tag, "_cnt"}, bus.CNT, 0);
    chk({tag, "_ledr"}, bus.LEDR, 10'b00_0001_0000);
  endtask
  task automatic txn(input vec_t t, input bit full);
    bus.SW = t.sw_a;
    press();
    if (full) chk("txn_wait_b", bus.STATE, 1);
    bus.SW = {2'b01, 4'b1010, t.sw_b};
    {bus.CMP_GT, bus.CMP_LT, bus.CMP_EQ} = t.flags;
    step_n = 1'b0;
    ticks(8);
    cnt_m = cnt_m + {7'd0, t.inc};
    chk("txn_cnt", bus.CNT, cnt_m);
    if (full) begin
      chk("txn_show", bus.STATE, 3);
      chk("txn_opa", bus.OPA, t.exp_opa);
      chk("txn_opb", bus.OPB, t.sw_b);
      chk("txn_mode", bus.MODE, t.exp_mode);
      chk("txn_led", bus.LEDR, {t.exp_mode, 4'b1000, t.exp_led});
    end
    step_n = 1'b1;
    ticks(8);
    bus.SW = 10'h3FF;
    press();
    if (full) begin
      chk("txn_exit", bus.STATE, 0);
      chk("txn_exit_led", bus.LEDR, {t.exp_mode, 4'b0001, 4'b0000});
      chk("txn_exit_opa", bus.OPA, t.exp_opa);
      chk("txn_exit_opb", bus.OPB, t.sw_b);
    end
  endtask
  initial begin
    vecs[0] = '{10'b01_0000_0011, 4'd7, 3'b010, 4'd3, 2'd1, 4'b0010, 1'b1};
    vecs[1] = '{10'b00_0000_1001, 4'd9, 3'b001, 4'd9, 2'd0, 4'b0001, 1'b1};
    vecs[2] = '{10'b11_0000_1111, 4'd2, 3'b101, 4'd15, 2'd3, 4'b1101, 1'b0};
    vecs[3] = '{10'b00_0000_0100, 4'd4, 3'b000, 4'd4, 2'd0, 4'b1000, 1'b0};
    vecs[4] = '{10'b01_0000_1000, 4'd1, 3'b111, 4'd8, 2'd1, 4'b1111, 1'b0};
    vecs[5] = '{10'b10_0000_1100, 4'd0, 3'b100, 4'd12, 2'd2, 4'b0100, 1'b1};
    bus.SW = '0;
    {bus.CMP_GT, bus.CMP_LT, bus.CMP_EQ} = 3'b000;
    ticks(2);
    check_reset("reset");
    rst_n = 1'b1;
    ticks(5);
    bus.SW = 10'b10_0000_0101;
    repeat (5) begin
      step_n = 1'b0;
      ticks(3);
      step_n = 1'b1;
      ticks(6);
    end
    chk("glitch_idle", bus.STATE, 0);
    step_n = 1'b0;
    ticks(6);
    step_n = 1'b1;
    ticks(1);
    chk("press6_state", bus.STATE, 1);
    chk("press6_opa", bus.OPA, 5);
    chk("press6_mode", bus.MODE, 2);
    ticks(12);
    chk("press6_single", bus.STATE, 1);
    bus.SW = 10'b01_1111_0001;
    {bus.CMP_GT, bus.CMP_LT, bus.CMP_EQ} = 3'b100;
    step_n = 1'b0;
    ticks(7);
    chk("capb_state", bus.STATE, 2);
    chk("capb_opb", bus.OPB, 1);
    ticks(1);
    cnt_m = 8'd1;
    chk("gt_state", bus.STATE, 3);
    chk("gt_res", bus.LEDR[3:0], 4'b0100);
    chk("gt_cnt", bus.CNT, cnt_m);
    chk("gt_opa", bus.OPA, 5);
    chk("gt_mode", bus.MODE, 2);
    chk("gt_ledr_hi", bus.LEDR[9:4], 6'b10_1000);
    step_n = 1'b1;
    ticks(19);
    chk("show_hold19", bus.STATE, 3);
    ticks(1);
    chk("show_timeout", bus.STATE, 0);
    chk("timeout_led", bus.LEDR[3:0], 0);
    chk("timeout_cnt", bus.CNT, cnt_m);
    chk("timeout_onehot", bus.LEDR[7:4], 4'b0001);
    for (int i = 0; i < 6; i++) txn(vecs[i], 1'b1);
    begin
      automatic int n = 256 - int'(cnt_m);
      automatic vec_t q = '{10'b00_0000_0011, 4'd3, 3'b001, 4'd3, 2'd0, 4'b0001, 1'b1};
      for (int i = 0; i < n; i++) txn(q, 1'b0);
    end
    chk("wrap_cnt", bus.CNT, 0);
    bus.SW = 10'b11_0000_0110;
    press();
    chk("pre_rst_wait_b", bus.STATE, 1);
    step_n = 1'b0;
    ticks(4);
    #1 rst_n = 1'b0;
    #1 check_reset("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    ticks(12);
    chk("held_no_event", bus.STATE, 0);
    step_n = 1'b1;
    ticks(12);
    chk("release_no_event", bus.STATE, 0);
    chk("release_opa", bus.OPA, 0);
    press();
    chk("rearm_state", bus.STATE, 1);
    chk("rearm_opa", bus.OPA, 6);
    chk("rearm_mode", bus.MODE, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/compare_sequencer.md
COMPARE_SEQUENCER -- requirements
Module: compare_sequencer

Interface
REQ-001 The module SHALL provide parameter DEBOUNCE_CYCLES, default 500000, giving the number of consecutive stable synchronized samples required to accept a new STEP_N level (10 ms at 50 MHz).
REQ-002 The module SHALL provide parameter SHOW_CYCLES, default 150000000, giving the SHOW-state display hold time in clocks (3 s at 50 MHz).
REQ-003 MAX10_CLK1_50  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 STEP_N  input  1  raw active-low step pushbutton, asynchronous to the clock, bouncing.
REQ-006 SW  input  10  slide switches: SW[3:0] operand value, SW[9:8] compare mode.
REQ-007 CMP_GT, CMP_LT, CMP_EQ  input  1 each  comparator datapath flags, combinational from OPA/OPB/MODE.
REQ-008 OPA, OPB  output  4 each  registered operands driven to the comparator.
REQ-009 MODE  output  2  registered compare mode driven to the comparator.
REQ-010 LEDR  output  10  status LEDs, mapped per REQ-021.
REQ-011 STATE  output  2  current FSM state code.
REQ-012 CNT  output  8  count of valid completed comparisons.

Function
REQ-013 STEP_N SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 The debounced level SHALL change only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive clocks; any return to the current level SHALL restart the count at zero.
REQ-015 A press event SHALL be a one-clock pulse on a 1->0 transition of the debounced level; a held button SHALL produce exactly one event, and a release SHALL produce none.
REQ-016 The FSM SHALL have states IDLE=0, WAIT_B=1, EVAL=2, SHOW=3.
REQ-017 IDLE: on a press, OPA<=SW[3:0], MODE<=SW[9:8], next state WAIT_B; otherwise the FSM SHALL remain in IDLE.
REQ-018 WAIT_B: on a press, OPB<=SW[3:0], next state EVAL; OPA and MODE SHALL hold.
REQ-019 EVAL SHALL last exactly one clock, serving as comparator settle time, then go to SHOW, and SHALL ignore presses.
REQ-020 On the EVAL->SHOW edge, the block SHALL register CMP_EQ/LT/GT into LEDR[0]/[1]/[2], so result LEDs are valid two clocks after the OPB-capture edge.
REQ-021 LEDR[3] SHALL be the error flag; LEDR[7:4] SHALL be one-hot state (bit 4+STATE); LEDR[9:8] SHALL equal MODE.
REQ-022 On the EVAL->SHOW edge, the error flag SHALL be set if the flags are not exactly one-hot and cleared otherwise; CNT SHALL increment (wrapping 255->0) only when the flags are one-hot.
REQ-023 SHOW: the hold timer SHALL start at zero on entry and increment each clock; on reaching SHOW_CYCLES-1 or on a press, whichever comes first, the FSM SHALL go to IDLE.
REQ-024 On SHOW->IDLE, LEDR[3:0] SHALL clear; OPA, OPB, MODE and CNT SHALL hold.
REQ-025 A press in SHOW SHALL only exit SHOW and SHALL NOT capture an operand.
REQ-026 A press and a timeout in the same clock SHALL produce one IDLE transition.
REQ-027 Switch changes SHALL NOT alter OPA, OPB or MODE except at the capture edges of REQ-017 and REQ-018.

Reset
REQ-028 Asserting RST_N low SHALL, immediately and regardless of state, force: STATE=IDLE, OPA=0, OPB=0, MODE=0, CNT=0, LEDR=10'b00_0001_0000, debounced level=1, all counters=0, synchronizer flops=1.
REQ-029 After RST_N deasserts, a press still held from before reset SHALL NOT generate an event until it is released and pressed again.

Verification (DEBOUNCE_CYCLES=4, SHOW_CYCLES=20)
REQ-030 The bench SHALL check: SW=10'b10_0000_0101, press; SW=0001, press -> OPA=5, OPB=1, MODE=2'b10; with CMP_GT stimulus, LEDR[2:0]=3'b100 two clocks after capture, CNT=1, STATE=3.
REQ-031 The bench SHALL check: STEP_N glitching low for 3 clocks, repeated 5 times -> no event, STATE stays 0; a 6-clock low -> exactly one event.
REQ-032 The bench SHALL check: in SHOW with no press -> IDLE exactly 20 clocks after entry, LEDR[3:0]=0, CNT unchanged.
REQ-033 The bench SHALL check: stimulus CMP_GT=CMP_EQ=1 at EVAL -> LEDR[3]=1, CNT not incremented.
REQ-034 The bench SHALL check: 256 valid comparisons -> CNT wraps to 0.
REQ-035 The bench SHALL check: RST_N pulsed low in WAIT_B mid-debounce -> all outputs equal REQ-028 values in the same cycle, with no spurious event after release.
